// File: rtl/jh512_core.sv
// jh512_core: iterative JH-512 compression function F8 (E8 over 42 rounds).
// Define JH512_UNROLL2_EN to evaluate two E8 rounds per ROUND cycle.
module jh512_core #(
    parameter int ROUNDS = 42
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1023:0] state,
    input  logic [127:0]  data,
    output logic [511:0]  hash,
    output logic          done
);

`ifdef JH512_UNROLL2_EN
    localparam int NCYC = ROUNDS / 2;
`else
    localparam int NCYC = ROUNDS;
`endif

    localparam logic [255:0] C0 =
        256'h6a09e667f3bcc908b2fb1366ea957d3e3adec17512775099da2f590b0667322a;
    localparam logic [63:0] SB0 = 64'h904bdc3f1a26758e;
    localparam logic [63:0] SB1 = 64'h3c6d5719f204bae8;

    typedef enum logic [1:0] {LOAD, ROUND, FINISH} fsm_t;

    fsm_t           st;
    fsm_t           st_nxt;
    logic [7:0]     cnt;
    logic [1023:0]  a;
    logic [255:0]   c;
    logic [127:0]   m;
    logic [1023:0]  a_nx;
    logic [255:0]   c_nx;
    logic           ld;
    logic           rnd;
    logic           fin;
    logic           last;

    function automatic logic [3:0] sbox(input logic sel, input logic [3:0] x);
        logic [63:0] t;
        logic [5:0]  idx;
        t   = sel ? SB1 : SB0;
        idx = {~x, 2'b00};
        return t[idx +: 4];
    endfunction

    // multiplication by 2 in GF(2^4) modulo x^4 + x + 1
    function automatic logic [3:0] mul2(input logic [3:0] x);
        return {x[2], x[1], x[0] ^ x[3], x[3]};
    endfunction

    function automatic logic [1023:0] r8(input logic [1023:0] x,
                                         input logic [255:0]  k);
        logic [3:0]    t [256];
        logic [3:0]    o [256];
        logic [3:0]    u;
        logic [1023:0] y;
        for (int i = 0; i < 256; i++)
            t[i] = sbox(k[255 - i], x[1023 - 4 * i -: 4]);
        for (int i = 0; i < 256; i += 2) begin
            t[i + 1] = t[i + 1] ^ mul2(t[i]);
            t[i]     = t[i] ^ mul2(t[i + 1]);
        end
        for (int i = 0; i < 256; i += 4) begin
            u        = t[i + 2];
            t[i + 2] = t[i + 3];
            t[i + 3] = u;
        end
        for (int i = 0; i < 128; i++) begin
            o[i]       = t[2 * i];
            o[i + 128] = t[2 * i + 1];
        end
        for (int i = 128; i < 256; i += 2) begin
            u        = o[i];
            o[i]     = o[i + 1];
            o[i + 1] = u;
        end
        for (int i = 0; i < 256; i++)
            y[1023 - 4 * i -: 4] = o[i];
        return y;
    endfunction

    // constant schedule: same round structure on 64 elements, all-S0
    function automatic logic [255:0] r6(input logic [255:0] x);
        logic [3:0]   t [64];
        logic [3:0]   o [64];
        logic [3:0]   u;
        logic [255:0] y;
        for (int i = 0; i < 64; i++)
            t[i] = sbox(1'b0, x[255 - 4 * i -: 4]);
        for (int i = 0; i < 64; i += 2) begin
            t[i + 1] = t[i + 1] ^ mul2(t[i]);
            t[i]     = t[i] ^ mul2(t[i + 1]);
        end
        for (int i = 0; i < 64; i += 4) begin
            u        = t[i + 2];
            t[i + 2] = t[i + 3];
            t[i + 3] = u;
        end
        for (int i = 0; i < 32; i++) begin
            o[i]      = t[2 * i];
            o[i + 32] = t[2 * i + 1];
        end
        for (int i = 32; i < 64; i += 2) begin
            u        = o[i];
            o[i]     = o[i + 1];
            o[i + 1] = u;
        end
        for (int i = 0; i < 64; i++)
            y[255 - 4 * i -: 4] = o[i];
        return y;
    endfunction

    // element 2i gathers bits i, i+256, i+512, i+768; element 2i+1 bits i+128...
    function automatic logic [1023:0] group(input logic [1023:0] h);
        logic [1023:0] g;
        for (int i = 0; i < 128; i++) begin
            g[1023 - 8 * i -: 4] = {h[1023 - i], h[767 - i],
                                    h[511 - i],  h[255 - i]};
            g[1019 - 8 * i -: 4] = {h[895 - i],  h[639 - i],
                                    h[383 - i],  h[127 - i]};
        end
        return g;
    endfunction

    // only the second half of the degrouped state is ever needed
    function automatic logic [511:0] degroup(input logic [1023:0] g);
        logic [511:0] h;
        for (int i = 0; i < 128; i++) begin
            h[511 - i] = g[1021 - 8 * i];
            h[255 - i] = g[1020 - 8 * i];
            h[383 - i] = g[1017 - 8 * i];
            h[127 - i] = g[1016 - 8 * i];
        end
        return h;
    endfunction

`ifdef JH512_UNROLL2_EN
    assign a_nx = r8(r8(a, c), r6(c));
    assign c_nx = r6(r6(c));
`else
    assign a_nx = r8(a, c);
    assign c_nx = r6(c);
`endif

    assign last = (cnt == 8'(NCYC - 1));

    always_ff @(posedge clk) begin
        if (rst)
            st <= LOAD;
        else
            st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        ld     = 1'b0;
        rnd    = 1'b0;
        fin    = 1'b0;
        unique case (st)
            LOAD: begin
                ld     = 1'b1;
                st_nxt = ROUND;
            end
            ROUND: begin
                rnd = 1'b1;
                if (last)
                    st_nxt = FINISH;
            end
            FINISH: begin
                fin    = 1'b1;
                st_nxt = LOAD;
            end
            default: st_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a    <= '0;
            c    <= '0;
            m    <= '0;
            cnt  <= '0;
            hash <= '0;
            done <= 1'b0;
        end else begin
            done <= fin;
            if (ld) begin
                a   <= group(state ^ {data, 896'b0});
                m   <= data;
                c   <= C0;
                cnt <= '0;
            end
            if (rnd) begin
                a   <= a_nx;
                c   <= c_nx;
                cnt <= cnt + 8'd1;
            end
            if (fin)
                hash <= degroup(a) ^ {m, 384'b0};
        end
    end

endmodule

// File: tb/tb_jh512_core.sv
// tb_jh512_core: directed bench with a byte-level F8 reference model.
// Expected digests are queued at each LOAD and matched on every done pulse.
module tb_jh512_core;

`ifdef JH512_UNROLL2_EN
    localparam int P = 23;
`else
    localparam int P = 44;
`endif

    localparam logic [511:0] KAT_EMPTY =
        512'h90ecf2f76f9d2c8017d979ad5ab96b87d58fc8fc4b83060f3f900774faa2c8fabe69c5f4ff1ec2b61d6b316941cedee117fb04b1f4c5bc1b919ae841c50eec4f;
    localparam logic [255:0] RC0 =
        256'h6a09e667f3bcc908b2fb1366ea957d3e3adec17512775099da2f590b0667322a;
    localparam logic [127:0] PAD_EMPTY = 128'h80000000000000000000000000000000;
    localparam logic [1023:0] ST_B = 1024'd345;
    localparam logic [127:0] DAT_B = 128'd7659432094555543122297600000000654;

    typedef struct {
        logic [511:0] d;
        int           t;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [1023:0] state;
    logic [127:0]  data;
    logic [511:0]  hash;
    logic          done;

    int            checks;
    int            errors;
    int            ncyc;
    logic [511:0]  held;
    logic [1023:0] iv;
    logic [511:0]  dig_b;
    exp_t          sb [$];

    int sbx [2][16] = '{'{9, 0, 4, 11, 13, 12, 3, 15, 1, 10, 2, 6, 7, 5, 8, 14},
                        '{3, 12, 6, 13, 5, 7, 1, 9, 15, 2, 0, 4, 11, 10, 14, 8}};

    jh512_core dut (
        .clk   (clk),
        .rst   (rst),
        .state (state),
        .data  (data),
        .hash  (hash),
        .done  (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [3:0] x2(input logic [3:0] v);
        int a;
        a = int'(v);
        return 4'(((a << 1) ^ (a >> 3) ^ ((a >> 2) & 2)) & 15);
    endfunction

    function automatic logic [1023:0] f8(input logic [1023:0] hin,
                                         input logic [127:0]  d);
        logic [7:0]    h [128];
        logic [7:0]    b [64];
        logic [3:0]    a [256];
        logic [3:0]    t [256];
        logic [3:0]    rc [64];
        logic [3:0]    t6 [64];
        logic [3:0]    s;
        logic [511:0]  mm;
        logic [1023:0] r;
        mm = {d, 384'b0};
        for (int i = 0; i < 128; i++) h[i] = hin[1023 - 8 * i -: 8];
        for (int i = 0; i < 64; i++) b[i] = mm[511 - 8 * i -: 8];
        for (int i = 0; i < 64; i++) h[i] = h[i] ^ b[i];
        for (int i = 0; i < 256; i++)
            t[i] = {h[i >> 3][7 - (i & 7)], h[(i + 256) >> 3][7 - (i & 7)],
                    h[(i + 512) >> 3][7 - (i & 7)], h[(i + 768) >> 3][7 - (i & 7)]};
        for (int i = 0; i < 128; i++) begin
            a[2 * i]     = t[i];
            a[2 * i + 1] = t[i + 128];
        end
        for (int i = 0; i < 64; i++) rc[i] = RC0[255 - 4 * i -: 4];
        for (int rd = 0; rd < 42; rd++) begin
            for (int i = 0; i < 256; i++)
                t[i] = 4'(sbx[rc[i >> 2][3 - (i & 3)]][a[i]]);
            for (int i = 0; i < 256; i += 2) begin
                t[i + 1] ^= x2(t[i]);
                t[i]     ^= x2(t[i + 1]);
            end
            for (int i = 0; i < 256; i += 4) begin
                s = t[i + 2]; t[i + 2] = t[i + 3]; t[i + 3] = s;
            end
            for (int i = 0; i < 128; i++) begin
                a[i]       = t[2 * i];
                a[i + 128] = t[2 * i + 1];
            end
            for (int i = 128; i < 256; i += 2) begin
                s = a[i]; a[i] = a[i + 1]; a[i + 1] = s;
            end
            for (int i = 0; i < 64; i++) t6[i] = 4'(sbx[0][rc[i]]);
            for (int i = 0; i < 64; i += 2) begin
                t6[i + 1] ^= x2(t6[i]);
                t6[i]     ^= x2(t6[i + 1]);
            end
            for (int i = 0; i < 64; i += 4) begin
                s = t6[i + 2]; t6[i + 2] = t6[i + 3]; t6[i + 3] = s;
            end
            for (int i = 0; i < 32; i++) begin
                rc[i]      = t6[2 * i];
                rc[i + 32] = t6[2 * i + 1];
            end
            for (int i = 32; i < 64; i += 2) begin
                s = rc[i]; rc[i] = rc[i + 1]; rc[i + 1] = s;
            end
        end
        for (int i = 0; i < 128; i++) begin
            t[i]       = a[2 * i];
            t[i + 128] = a[2 * i + 1];
        end
        for (int i = 0; i < 256; i++) begin
            h[i >> 3][7 - (i & 7)]         = t[i][3];
            h[(i + 256) >> 3][7 - (i & 7)] = t[i][2];
            h[(i + 512) >> 3][7 - (i & 7)] = t[i][1];
            h[(i + 768) >> 3][7 - (i & 7)] = t[i][0];
        end
        for (int i = 0; i < 64; i++) h[64 + i] = h[64 + i] ^ b[i];
        for (int i = 0; i < 128; i++) r[1023 - 8 * i -: 8] = h[i];
        return r;
    endfunction

    function automatic logic [1023:0] rnd1024();
        logic [1023:0] r;
        for (int i = 0; i < 32; i++) r[32 * i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs,
                       input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [511:0] d);
        exp_t e;
        e.d = d;
        e.t = ncyc + P;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(negedge clk);
        ncyc++;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_done", {511'b0, done}, 512'b0);
            end else begin
                e = sb.pop_front();
                chk("digest", hash, e.d);
                chk("latency", 512'(ncyc), 512'(e.t));
                held = e.d;
            end
        end else begin
            chk("hold", hash, held);
            if (sb.size() > 0 && ncyc >= sb[0].t) begin
                chk("done_missing", {511'b0, done}, 512'd1);
                void'(sb.pop_front());
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        ncyc   = 0;
        held   = '0;
        rst    = 1'b1;
        state  = '0;
        data   = '0;
        iv     = f8({16'h0200, 1008'b0}, 128'b0);
        dig_b  = f8(ST_B, DAT_B) >> 0;

        for (int i = 0; i < 3; i++) begin
            state = rnd1024();
            data  = rnd128();
            tick();
            chk("rst_done", {511'b0, done}, 512'b0);
        end

        state = iv;
        data  = PAD_EMPTY;
        rst   = 1'b0;
        push(KAT_EMPTY);
        for (int k = 1; k <= P; k++) begin
            tick();
            if (k < P) begin
                state = rnd1024();
                data  = rnd128();
            end
        end

        state = ST_B;
        data  = DAT_B;
        for (int p = 0; p < 3; p++) begin
            push(dig_b);
            repeat (P) tick();
        end

        state = iv;
        data  = PAD_EMPTY;
        repeat (21) tick();
        rst  = 1'b1;
        held = '0;
        tick();
        chk("midrst_done", {511'b0, done}, 512'b0);
        rst   = 1'b0;
        state = ST_B;
        data  = DAT_B;
        push(dig_b);
        repeat (P) tick();

        state = iv;
        data  = PAD_EMPTY;
        push(KAT_EMPTY);
        repeat (P) tick();

        repeat (5) tick();
        chk("queue_empty", 512'(sb.size()), 512'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
